// File: rtl/alu_result_buffer_if.sv
// -----------------------------------------------------------------------------
// alu_result_buffer_if
// Purpose : bundles the producer-side and consumer-side handshakes of the ALU
//           result buffer so the buffer and its neighbours connect by one port.
// Signals :
//   in_valid      producer has a result this cycle
//   in_ready      buffer can accept a result
//   resultado     selected 32-bit ALU result
//   f_op          opcode {f3,f2,f1,f0}; f_op[2]=1 arithmetic, 0 boolean
//   c_out         adder carry out
//   overflow      adder signed overflow
//   out_valid     head entry available
//   out_ready     consumer accepts the head entry
//   out_resultado head result
//   out_op        head opcode
//   out_flags     head flags {C,Z,N,V}
//   count         current occupancy
// Modports: master = producer/consumer side (drives in_*, out_ready),
//           slave  = the buffer itself.
// -----------------------------------------------------------------------------
interface alu_result_buffer_if #(
   parameter int CW = 3
);
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   resultado;
   logic [3:0]    f_op;
   logic          c_out;
   logic          overflow;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_resultado;
   logic [3:0]    out_op;
   logic [3:0]    out_flags;
   logic [CW-1:0] count;

   modport master (
      output in_valid, resultado, f_op, c_out, overflow, out_ready,
      input  in_ready, out_valid, out_resultado, out_op, out_flags, count
   );

   modport slave (
      input  in_valid, resultado, f_op, c_out, overflow, out_ready,
      output in_ready, out_valid, out_resultado, out_op, out_flags, count
   );
endinterface

// File: rtl/alu_result_buffer.sv
// -----------------------------------------------------------------------------
// alu_result_buffer
// Purpose : registered output stage behind the ALU result multiplexer. Each
//           accepted result is stored with its opcode and a locally formed
//           flag nibble {C,Z,N,V} in a DEPTH-entry FIFO and handed to the
//           register-file writeback over a valid/ready handshake.
// Ports   :
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus        alu_result_buffer_if.slave (see interface header)
//   clr_sticky (ALU_STICKY_OVF_EN only) clear request for sticky_ovf
//   sticky_ovf (ALU_STICKY_OVF_EN only) set by any accepted push with V=1
// Parameters: DEPTH (power of two, >= 2), CW = log2(DEPTH)+1.
// Optional feature macro: ALU_STICKY_OVF_EN.
// -----------------------------------------------------------------------------
module alu_result_buffer #(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   alu_result_buffer_if.slave   bus
`ifdef ALU_STICKY_OVF_EN
   ,
   input  logic                 clr_sticky,
   output logic                 sticky_ovf
`endif
);

   localparam int AW = $clog2(DEPTH);

   logic [31:0]   res_mem [DEPTH];
   logic [3:0]    op_mem  [DEPTH];
   logic [3:0]    flg_mem [DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q,  count_d;

   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic [3:0]    flag_in;

   // Handshake: a transfer happens on a rising edge where valid & ready are
   // both high. in_ready depends only on the registered count (never on
   // out_ready), so a full buffer refuses a push even in a cycle that pops.
   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign push  = bus.in_valid & ~full;
   assign pop   = ~empty & bus.out_ready;

   // Z and N come from the result itself; C and V are meaningless for
   // boolean operations, so they are masked by the arithmetic bit f_op[2].
   assign flag_in = {bus.c_out & bus.f_op[2],
                     (bus.resultado == 32'd0),
                     bus.resultado[31],
                     bus.overflow & bus.f_op[2]};

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; entries are only observable while counted.
   always_ff @(posedge clk) begin
      if (push) begin
         res_mem[wr_ptr_q] <= bus.resultado;
         op_mem[wr_ptr_q]  <= bus.f_op;
         flg_mem[wr_ptr_q] <= flag_in;
      end
   end

   assign bus.in_ready      = ~full;
   assign bus.out_valid     = ~empty;
   assign bus.count         = count_q;
   // Head is forced to zero when empty so stale storage never leaks out.
   assign bus.out_resultado = empty ? 32'd0 : res_mem[rd_ptr_q];
   assign bus.out_op        = empty ? 4'd0  : op_mem[rd_ptr_q];
   assign bus.out_flags     = empty ? 4'd0  : flg_mem[rd_ptr_q];

`ifdef ALU_STICKY_OVF_EN
   logic sticky_q, sticky_d;

   // A set and a clear in the same cycle resolve to set.
   always_comb begin
      sticky_d = sticky_q;
      if (clr_sticky)          sticky_d = 1'b0;
      if (push && flag_in[0])  sticky_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sticky_q <= 1'b0;
      else        sticky_q <= sticky_d;
   end

   assign sticky_ovf = sticky_q;
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// -----------------------------------------------------------------------------
// tb_alu_result_buffer
// Directed bench for alu_result_buffer: flag-formation vectors from a table,
// then hand-written fill/drain, simultaneous push/pop, optional sticky
// overflow and asynchronous mid-stream reset sequences. Inputs change on the
// falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_alu_result_buffer;

   localparam int DEPTH = 4;
   localparam int CW    = 3;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst_n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   alu_result_buffer_if #(.CW(CW)) bus ();

`ifdef ALU_STICKY_OVF_EN
   logic clr_sticky;
   logic sticky_ovf;
`endif

   alu_result_buffer #(.DEPTH(DEPTH), .CW(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus)
`ifdef ALU_STICKY_OVF_EN
      ,
      .clr_sticky (clr_sticky),
      .sticky_ovf (sticky_ovf)
`endif
   );

   // ---------------- scoreboard ----------------
   logic [31:0] exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic v, input logic [31:0] r, input logic [3:0] op,
                        input logic c, input logic ov);
      bus.in_valid  = v;
      bus.resultado = r;
      bus.f_op      = op;
      bus.c_out     = c;
      bus.overflow  = ov;
   endtask

   // Checks the occupancy/head against the model, then advances one clock
   // and applies the push/pop the model predicts for that edge.
   task automatic tick();
      logic        do_pop;
      logic        do_push;
      logic [31:0] res;
      check("count",     32'(bus.count),      32'(exp_q.size()));
      check("out_valid", 32'(bus.out_valid),  32'(exp_q.size() != 0));
      check("in_ready",  32'(bus.in_ready),   32'(exp_q.size() < DEPTH));
      if (exp_q.size() != 0) check("head", bus.out_resultado, exp_q[0]);
      else                   check("empty_head_zero", bus.out_resultado, 32'd0);
      do_pop  = bus.out_ready && (exp_q.size() != 0);
      do_push = bus.in_valid  && (exp_q.size() < DEPTH);
      res     = bus.resultado;
      @(posedge clk);
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(res);
      @(negedge clk);
   endtask

   task automatic drain();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 3 * DEPTH && exp_q.size() != 0; k++) tick();
      bus.out_ready = 1'b0;
      check("drained_count", 32'(bus.count), 32'd0);
   endtask

   // ---------------- vectors ----------------
   typedef struct {
      logic [31:0] res;
      logic [3:0]  op;
      logic        c;
      logic        v;
      logic [3:0]  flags;   // expected {C,Z,N,V}
   } vec_t;

   vec_t vecs[6];

   initial begin
      vecs[0] = '{32'h8000_0002, 4'b0100, 1'b1, 1'b1, 4'b1011};
      vecs[1] = '{32'h0000_0000, 4'b1001, 1'b1, 1'b1, 4'b0100};
      vecs[2] = '{32'h0000_0000, 4'b0110, 1'b1, 1'b0, 4'b1100};
      vecs[3] = '{32'hFFFF_FFFF, 4'b0011, 1'b1, 1'b1, 4'b0010};
      vecs[4] = '{32'h7FFF_FFFF, 4'b0101, 1'b0, 1'b1, 4'b0001};
      vecs[5] = '{32'h0000_0001, 4'b1110, 1'b0, 1'b0, 4'b0000};

      // ---- reset with in_valid held high ----
      rst_n = 1'b0;
      drive(1'b1, 32'hDEAD_BEEF, 4'b0100, 1'b1, 1'b1);
      bus.out_ready = 1'b0;
`ifdef ALU_STICKY_OVF_EN
      clr_sticky = 1'b0;
`endif
      repeat (2) @(negedge clk);
      check("rst_count",     32'(bus.count),     32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_in_ready",  32'(bus.in_ready),  32'd1);
      check("rst_resultado", bus.out_resultado,  32'd0);
      check("rst_op",        32'(bus.out_op),    32'd0);
      check("rst_flags",     32'(bus.out_flags), 32'd0);
`ifdef ALU_STICKY_OVF_EN
      check("rst_sticky",    32'(sticky_ovf),    32'd0);
`endif
      rst_n = 1'b1;
      drive(1'b0, 32'd0, 4'd0, 1'b0, 1'b0);
      tick();
      check("idle_out_valid", 32'(bus.out_valid), 32'd0);

      // ---- flag formation, one push and one pop per vector ----
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, vecs[i].res, vecs[i].op, vecs[i].c, vecs[i].v);
         bus.out_ready = 1'b0;
         tick();
         drive(1'b0, 32'd0, 4'd0, 1'b0, 1'b0);
         check($sformatf("vec%0d_flags", i), 32'(bus.out_flags), 32'(vecs[i].flags));
         check($sformatf("vec%0d_op", i),    32'(bus.out_op),    32'(vecs[i].op));
         check($sformatf("vec%0d_res", i),   bus.out_resultado,  vecs[i].res);
         bus.out_ready = 1'b1;
         tick();
         bus.out_ready = 1'b0;
      end

      // ---- fill, hold 0x14 while full, then drain ----
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h10 + 32'(i), 4'b0100, 1'b0, 1'b0);
         tick();
      end
      drive(1'b1, 32'h14, 4'b0100, 1'b0, 1'b0);
      check("fill_count",    32'(bus.count),    32'd4);
      check("fill_in_ready", 32'(bus.in_ready), 32'd0);
      tick();                                   // 0x14 refused
      check("full_hold_count", 32'(bus.count), 32'd4);
      bus.out_ready = 1'b1;
      tick();                                   // pop 0x10 only
      check("first_pop_count", 32'(bus.count), 32'd3);
      check("first_pop_head",  bus.out_resultado, 32'h11);
      tick();                                   // pop 0x11, accept 0x14
      check("push14_count", 32'(bus.count), 32'd3);
      bus.in_valid = 1'b0;
      drain();

      // ---- simultaneous push/pop across pointer wrap ----
      drive(1'b1, 32'hA0, 4'b0100, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'hA1, 4'b0100, 1'b0, 1'b0);
      tick();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 32'h20 + 32'(i), 4'b0100, 1'b0, 1'b0);
         tick();
         check($sformatf("ss_count%0d", i), 32'(bus.count), 32'd2);
      end
      check("ss_head", bus.out_resultado, 32'h28);
      drain();

`ifdef ALU_STICKY_OVF_EN
      // ---- sticky overflow ----
      clr_sticky = 1'b1;
      tick();
      clr_sticky = 1'b0;
      check("sticky_cleared", 32'(sticky_ovf), 32'd0);
      drive(1'b1, 32'h0, 4'b1001, 1'b1, 1'b1);   // boolean: V masked
      tick();
      check("sticky_bool", 32'(sticky_ovf), 32'd0);
      drive(1'b1, 32'h5, 4'b0100, 1'b0, 1'b1);   // set races clear, set wins
      clr_sticky = 1'b1;
      tick();
      clr_sticky = 1'b0;
      check("sticky_set_wins", 32'(sticky_ovf), 32'd1);
      bus.in_valid = 1'b0;
      tick();
      check("sticky_holds", 32'(sticky_ovf), 32'd1);
      clr_sticky = 1'b1;
      tick();
      clr_sticky = 1'b0;
      check("sticky_clr", 32'(sticky_ovf), 32'd0);
      drain();
`endif

      // ---- asynchronous reset mid-stream ----
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h30 + 32'(i), 4'b0100, 1'b0, 1'b1);
         tick();
      end
      bus.in_valid = 1'b0;
      check("pre_rst_count", 32'(bus.count), 32'd3);
`ifdef ALU_STICKY_OVF_EN
      check("pre_rst_sticky", 32'(sticky_ovf), 32'd1);
`endif
      #2 rst_n = 1'b0;
      #1;
      check("arst_count",     32'(bus.count),     32'd0);
      check("arst_out_valid", 32'(bus.out_valid), 32'd0);
      check("arst_in_ready",  32'(bus.in_ready),  32'd1);
      check("arst_resultado", bus.out_resultado,  32'd0);
`ifdef ALU_STICKY_OVF_EN
      check("arst_sticky",    32'(sticky_ovf),    32'd0);
`endif
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 32'h55, 4'b0100, 1'b0, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      check("post_rst_head",  bus.out_resultado, 32'h55);
      check("post_rst_count", 32'(bus.count),    32'd1);
      drain();

      // ---- final report ----
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
